// File: rtl/act_unpack_serializer.sv
// Unpacks a NUM-lane packed activation frame and streams it out one lane per beat, lane 0 first.
// Optional frame counter output enabled by defining ACT_UNPACK_FRAME_CNT_EN.
module act_unpack_serializer #(
  parameter int NUM           = 4,
  parameter int WIDTH         = 16,
  parameter int DECIMAL_POINT = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM*WIDTH-1:0]   in_signal,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   out_ge_one
`ifdef ACT_UNPACK_FRAME_CNT_EN
  ,
  output logic [15:0]            frame_cnt
`endif
);

  localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1) << DECIMAL_POINT;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM*WIDTH-1:0]   r_hold;
  logic [IW-1:0]          r_idx;
  logic [WIDTH-1:0]       w_lane;
  logic                   w_last_idx;
  logic                   w_take;
  logic                   w_xfer;

  always_comb begin
    w_lane = '0;
    for (int unsigned k = 0; k < NUM; k++) begin
      if (r_idx == IW'(k)) w_lane = r_hold[(NUM-1-k)*WIDTH +: WIDTH];
    end
  end

  assign w_last_idx = (r_idx == IW'(NUM - 1));
  assign out_valid  = (r_state == SEND);
  assign out_data   = out_valid ? w_lane : '0;
  assign out_last   = out_valid && w_last_idx;
  // Sign-extend by one bit so 1.0 is representable even when DECIMAL_POINT = WIDTH-1.
  assign out_ge_one = out_valid && ($signed({out_data[WIDTH-1], out_data}) >= $signed(ONE));
  assign w_xfer     = out_valid && out_ready;
  assign in_ready   = rst && ((r_state == IDLE) || (w_xfer && out_last));
  assign w_take     = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_nxt = SEND;
      SEND:    if (w_xfer && out_last && !w_take) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_hold <= in_signal;
        r_idx  <= '0;
      end else if (w_xfer) begin
        r_idx <= w_last_idx ? '0 : r_idx + IW'(1);
      end
    end
  end

`ifdef ACT_UNPACK_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                    frame_cnt <= '0;
    else if (w_xfer && out_last) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule
